uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Parametrised UART receiver with configurable oversampling, data width, parity mode and stop-bit count.
- Adds start-bit validation, mid-bit majority voting, parity/framing/overrun/break detection, and a valid/ready output handshake with a one-entry holding register.
- Sits between the rx pin (via its own synchroniser) and the byte consumer; successor to the fixed 8N1 x4 receiver.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 4, clk posedges per bit (even, >=4).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked (1 or 2).

Ports:
- clk  in  1  OVERSAMPLE x baud clock.
- res_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, asynchronous, idle high.
- rx_data  out  DATA_BITS  received word, stable while rx_valid.
- rx_valid  out  1  word available.
- rx_ready  in  1  consumer accepts word when rx_valid && rx_ready.
- parity_err  out  1  parity mismatch for the held word (0 when PARITY=0).
- frame_err  out  1  any stop bit voted low for the held word.
- overrun  out  1  sticky: a frame completed while the holding register was full.
- break_det  out  1  high while in BREAK state.

Behaviour:
- Reset (async, res_n low): state IDLE, all counters 0, synchroniser flops 1, rx_data 0, all flags 0. Reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchroniser (reset value 1) before any use; all timings below are relative to the synchronised signal rs.
- Bit timing: phase counter ph counts 0..OVERSAMPLE-1, starting at 0 on the first cycle rs is seen low in IDLE. H = OVERSAMPLE/2.
- Sampling: rs is sampled at ph = H-1, H and H+1. Vote = majority of the 3 samples, taken at ph = OVERSAMPLE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START when rs = 0.
  - START: vote 1 (false start/glitch) -> IDLE with no output; vote 0 -> DATA.
  - DATA: vote shifted in LSB-first. After DATA_BITS votes -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: expected bit = XOR of data (even) or its inverse (odd); mismatch latches the pending parity error.
  - STOP: STOP_BITS votes; any 0 sets the pending frame error. After the last vote, deliver and go to IDLE.
  - Break exception: if frame error and data == 0 (and parity bit == 0 when present), deliver, then -> BREAK instead of IDLE.
  - BREAK: break_det = 1; stay until rs = 1 for OVERSAMPLE consecutive cycles -> IDLE.
- Delivery, at the clk edge of the final stop vote:
  - If rx_valid = 0 or (rx_valid && rx_ready) in that same cycle: load rx_data, parity_err, frame_err; rx_valid = 1 the next cycle.
  - Otherwise (holding register full, no accept): overrun <= 1, new word dropped, held word unchanged.
- Handshake: rx_valid && rx_ready clears rx_valid the next cycle unless a simultaneous delivery reloads it. That accept also clears overrun, unless the same-cycle delivery itself overruns, which cannot occur because the register frees in that cycle.
- Latency: last stop vote to rx_valid = 1 cycle. Next start edge is detected immediately in IDLE; back-to-back frames need no idle gap.
- Width rules: ph is clog2(OVERSAMPLE) bits; bit counter is clog2(DATA_BITS+1) bits; no wrap beyond terminal counts.

Decomposition:
- Package uart_pkg: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the rx state encoding.
- One sub-module, uart_bit_sampler: synchroniser, phase counter, 3-sample majority vote. Outputs rs, the vote value and a vote strobe.
- The FSM, shift register, error logic and holding register stay in uart_rx_frame.

Test Plan:
1. Defaults (x4, 8N1): send 0xA5, rx_ready = 1 -> one rx_valid pulse with rx_data = 0xA5, parity_err = 0, frame_err = 0.
2. Glitch: rx low for 1 cycle, then high -> no rx_valid, FSM back in IDLE; a following 0x3C frame is received correctly. Also verify a single corrupted sample at ph = H inside a data bit is outvoted.
3. PARITY = 1, DATA_BITS = 7: send 0x55 with parity bit 1 (wrong) -> rx_data = 0x55, parity_err = 1. Resend with parity 0 -> parity_err = 0.
4. STOP_BITS = 2: send 0x0F with second stop bit low -> frame_err = 1, rx_data = 0x0F, break_det stays 0.
5. Overrun: send 0x11 then 0x22 with rx_ready = 0 -> rx_data = 0x11, overrun = 1. Then rx_ready = 1 for one cycle -> rx_valid = 0 and overrun = 0. Next frame 0x33 delivered normally.
6. Break and reset: hold rx low for 20 bit times -> exactly one word 0x00 with frame_err = 1, break_det = 1 until the line is high for OVERSAMPLE cycles. Separately, assert res_n low mid-frame -> all outputs 0 immediately, no partial word delivered after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity mode codes and
// the receive FSM state encoding.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Output side of the UART receiver: received word, status flags and the
// valid/ready handshake towards the byte consumer.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 break_det;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun, break_det,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun, break_det,
    output rx_ready
  );
endinterface

// File: rtl/uart_bit_sampler.sv
// Synchronises the serial line, tracks the in-bit phase and produces a
// majority vote of three mid-bit samples once per bit period.
module uart_bit_sampler #(
  parameter int OVERSAMPLE = 4
) (
  input  logic clk,
  input  logic res_n,
  input  logic rx,
  input  logic idle,
  input  logic run,
  output logic rs,
  output logic vote,
  output logic vote_stb
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int H    = OVERSAMPLE / 2;
  localparam logic [PH_W-1:0] PH_A    = PH_W'(H - 1);
  localparam logic [PH_W-1:0] PH_B    = PH_W'(H);
  localparam logic [PH_W-1:0] PH_C    = PH_W'(H + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

  logic            sync_p0, sync_p1;
  logic [PH_W-1:0] ph;
  logic            smp_a, smp_b, smp_c;
  logic            smp_c_now;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // stage p0/p1: two-flop synchroniser, idle-high reset value
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx;
      sync_p1 <= sync_p0;
    end
  end

  assign rs = sync_p1;

  // The first low cycle seen in IDLE is phase 0, so the next cycle is phase 1.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ph <= '0;
    end else if (run) begin
      ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end else if (idle && !rs) begin
      ph <= PH_W'(1);
    end else begin
      ph <= '0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
      smp_c <= 1'b1;
    end else if (run) begin
      if (ph == PH_A) smp_a <= rs;
      if (ph == PH_B) smp_b <= rs;
      if (ph == PH_C) smp_c <= rs;
    end
  end

  // At OVERSAMPLE=4 the third sample point coincides with the vote cycle.
  assign smp_c_now = (ph == PH_C) ? rs : smp_c;
  assign vote      = maj3(smp_a, smp_b, smp_c_now);
  assign vote_stb  = run && (ph == PH_LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start validation, LSB-first data, optional parity, 1-2
// stop bits, break detection and a one-entry valid/ready holding register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             rx,
  uart_rx_frame_if.master  bus
);

  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam int BK_W = $clog2(OVERSAMPLE);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(DATA_BITS - 1);
  localparam logic [BK_W-1:0] BK_LAST   = BK_W'(OVERSAMPLE - 1);
  localparam logic            STOP_LAST = (STOP_BITS == 2);
  localparam bit              HAS_PAR   = (PARITY != PAR_NONE);

  rx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BC_W-1:0]      bit_cnt;
  logic                 stop_cnt;
  logic [BK_W-1:0]      brk_cnt;
  logic                 par_bit, par_pend, frm_pend;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q, brk_q;

  logic rs, vote, vote_stb;
  logic idle, run;
  logic deliver, ferr_now, is_break, accept;

  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
    case (PARITY)
      PAR_EVEN: return ^d;
      PAR_ODD:  return ~^d;
      default:  return 1'b0;
    endcase
  endfunction

  assign idle = (state == ST_IDLE);
  assign run  = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};

  uart_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .res_n    (res_n),
    .rx       (rx),
    .idle     (idle),
    .run      (run),
    .rs       (rs),
    .vote     (vote),
    .vote_stb (vote_stb)
  );

  assign deliver  = (state == ST_STOP) && vote_stb && (stop_cnt == STOP_LAST);
  assign ferr_now = frm_pend | ~vote;
  assign is_break = ferr_now && (shreg == '0) && (!HAS_PAR || !par_bit);
  assign accept   = valid_q && bus.rx_ready;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      brk_cnt  <= '0;
      par_bit  <= 1'b0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rs) begin
            state    <= ST_START;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            par_pend <= 1'b0;
            frm_pend <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_stb) state <= vote ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (vote_stb) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BC_LAST) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (vote_stb) begin
            par_bit  <= vote;
            par_pend <= (vote != exp_parity(shreg));
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (vote_stb) begin
            if (!vote) frm_pend <= 1'b1;
            if (stop_cnt == STOP_LAST) begin
              if (is_break) begin
                state   <= ST_BREAK;
                brk_q   <= 1'b1;
                brk_cnt <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          // Leave only after a full bit time of continuous idle line.
          if (rs) begin
            if (brk_cnt == BK_LAST) begin
              state   <= ST_IDLE;
              brk_q   <= 1'b0;
              brk_cnt <= '0;
            end else begin
              brk_cnt <= brk_cnt + 1'b1;
            end
          end else begin
            brk_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register: an accept in the delivery cycle frees the slot for the new word.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (deliver) begin
        if (!valid_q || bus.rx_ready) begin
          data_q  <= shreg;
          perr_q  <= par_pend;
          ferr_q  <= ferr_now;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: two configurations (8N1 x4 and 7E2 x6) driven with
// directed and random frames, checked by a queue scoreboard at the handshake.
module tb_uart_rx_frame;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  logic rx0   = 1'b1;
  logic rx1   = 1'b1;

  int checks   = 0;
  int failures = 0;
  int words0   = 0;
  int words1   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  uart_rx_frame_if #(.DATA_BITS(8)) b0 ();
  uart_rx_frame_if #(.DATA_BITS(7)) b1 ();

  uart_rx_frame u0 (
    .clk   (clk),
    .res_n (res_n),
    .rx    (rx0),
    .bus   (b0)
  );

  uart_rx_frame #(
    .DATA_BITS (7),
    .OVERSAMPLE(6),
    .PARITY    (1),
    .STOP_BITS (2)
  ) u1 (
    .clk   (clk),
    .res_n (res_n),
    .rx    (rx1),
    .bus   (b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: pop the oldest expectation whenever a word is handed over.
  always @(negedge clk) begin
    if (res_n && b0.rx_valid && b0.rx_ready) begin
      words0++;
      check("dut0 word expected", (q0.size() > 0), 1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("dut0 rx_data", b0.rx_data, e0.data);
        check("dut0 parity_err", b0.parity_err, e0.perr);
        check("dut0 frame_err", b0.frame_err, e0.ferr);
      end
    end
  end

  always @(negedge clk) begin
    if (res_n && b1.rx_valid && b1.rx_ready) begin
      words1++;
      check("dut1 word expected", (q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("dut1 rx_data", b1.rx_data, e1.data);
        check("dut1 parity_err", b1.parity_err, e1.perr);
        check("dut1 frame_err", b1.frame_err, e1.ferr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0d required=%0d", $time, 1_000_000);
    $fatal(1, "timeout");
  end

  task automatic cyc(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int which, input int n);
    for (int i = 0; i < n; i++) cyc(which, 1'b1);
  endtask

  // Reference: frame layout and the expected delivered word follow directly
  // from the serial frame format; cbit>=0 flips one mid-bit sample of that data bit.
  task automatic send(input int which, input logic [8:0] data, input int nb, input int os,
                      input int par, input logic pflip, input int nstop,
                      input logic [1:0] stops, input int cbit, input bit expect_del,
                      output bit brk);
    logic [15:0] bits;
    logic [8:0]  dm;
    logic        pb;
    int          n;
    exp_t        e;
    bit          ferr;
    dm = data & ((9'd1 << nb) - 9'd1);
    bits = '0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      bits[n] = dm[i];
      n++;
    end
    pb = ((^dm) ^ (par == 2)) ^ pflip;
    if (par != 0) begin
      bits[n] = pb;
      n++;
    end
    ferr = 0;
    for (int i = 0; i < nstop; i++) begin
      bits[n] = stops[i];
      if (!stops[i]) ferr = 1;
      n++;
    end
    e.data = dm;
    e.perr = (par != 0) && (pb != ((^dm) ^ (par == 2)));
    e.ferr = ferr;
    brk = ferr && (dm == 0) && (par == 0 || pb == 1'b0);
    if (expect_del) begin
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < os; c++) begin
        if (i == cbit + 1 && c == os / 2) cyc(which, ~bits[i]);
        else                              cyc(which, bits[i]);
      end
    end
  endtask

  initial begin
    bit   brk;
    int   w;
    int   gap;
    logic [1:0] st;
    b0.rx_ready = 1'b1;
    b1.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_valid", {b0.rx_valid, b1.rx_valid}, 0);
    check("reset rx_data", {b0.rx_data, b1.rx_data}, 0);
    check("reset flags", {b0.parity_err, b0.frame_err, b0.overrun, b0.break_det,
                          b1.parity_err, b1.frame_err, b1.overrun, b1.break_det}, 0);
    res_n = 1'b1;
    idle(0, 5);

    // 8N1 basic word
    send(0, 9'hA5, 8, 4, 0, 0, 1, 2'b11, -1, 1, brk);
    idle(0, 8);

    // one-cycle glitch must not produce a word
    w = words0;
    cyc(0, 1'b0);
    idle(0, 12);
    check("glitch no word", words0, w);
    send(0, 9'h3C, 8, 4, 0, 0, 1, 2'b11, 3, 1, brk);
    idle(0, 8);

    // random back-to-back frames with one outvoted sample each
    for (int k = 0; k < 25; k++) begin
      send(0, 9'($urandom_range(0, 255)), 8, 4, 0, 0, 1, 2'b11,
           $urandom_range(0, 8) - 1, 1, brk);
      idle(0, $urandom_range(0, 3));
    end
    idle(0, 8);

    // overrun: second word dropped while the first is held
    b0.rx_ready = 1'b0;
    send(0, 9'h11, 8, 4, 0, 0, 1, 2'b11, -1, 1, brk);
    send(0, 9'h22, 8, 4, 0, 0, 1, 2'b11, -1, 0, brk);
    idle(0, 6);
    check("ovr held valid", b0.rx_valid, 1);
    check("ovr held data", b0.rx_data, 8'h11);
    check("ovr flag set", b0.overrun, 1);
    b0.rx_ready = 1'b1;
    idle(0, 1);
    b0.rx_ready = 1'b0;
    check("ovr accept clears valid", b0.rx_valid, 0);
    check("ovr accept clears flag", b0.overrun, 0);
    b0.rx_ready = 1'b1;
    send(0, 9'h33, 8, 4, 0, 0, 1, 2'b11, -1, 1, brk);
    idle(0, 8);
    check("ovr stays clear", b0.overrun, 0);

    // break: 20 bit times low gives exactly one zero word with frame error
    w = words0;
    q0.push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1});
    for (int i = 0; i < 80; i++) cyc(0, 1'b0);
    check("break_det high", b0.break_det, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1'b1);
    check("break_det held", b0.break_det, 1);
    cyc(0, 1'b1);
    check("break_det released", b0.break_det, 0);
    check("break one word", words0 - w, 1);
    idle(0, 8);

    // 7E2 x6: wrong then correct parity
    send(1, 9'h55, 7, 6, 1, 1, 2, 2'b11, -1, 1, brk);
    idle(1, 4);
    send(1, 9'h55, 7, 6, 1, 0, 2, 2'b11, 2, 1, brk);
    idle(1, 4);
    // second stop bit low: frame error, no break
    send(1, 9'h0F, 7, 6, 1, 0, 2, 2'b01, -1, 1, brk);
    idle(1, 3);
    check("dut1 no break on 0x0F", b1.break_det, 0);
    idle(1, 6);
    // zero data, zero parity, stop low: break
    send(1, 9'h00, 7, 6, 1, 0, 2, 2'b00, -1, 1, brk);
    cyc(1, 1'b0);
    cyc(1, 1'b0);
    check("dut1 break_det", b1.break_det, 1);
    idle(1, 9);
    check("dut1 break released", b1.break_det, 0);

    for (int k = 0; k < 25; k++) begin
      st  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send(1, 9'($urandom_range(0, 127)), 7, 6, 1, ($urandom_range(0, 3) == 0), 2, st,
           $urandom_range(0, 7) - 1, 1, brk);
      gap = $urandom_range(0, 2);
      if (brk) gap += 9;
      idle(1, gap);
    end
    idle(1, 10);

    // reset mid-frame with a word held
    b0.rx_ready = 1'b0;
    send(0, 9'h5A, 8, 4, 0, 0, 1, 2'b11, -1, 1, brk);
    idle(0, 6);
    check("pre-reset valid", b0.rx_valid, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1'b0);
    #2;
    res_n = 1'b0;
    rx0   = 1'b1;
    #1;
    check("async reset valid", b0.rx_valid, 0);
    check("async reset data", b0.rx_data, 0);
    check("async reset flags", {b0.parity_err, b0.frame_err, b0.overrun, b0.break_det}, 0);
    if (q0.size() > 0) void'(q0.pop_back());
    w = words0;
    @(posedge clk);
    @(posedge clk);
    #1;
    res_n = 1'b1;
    b0.rx_ready = 1'b1;
    idle(0, 60);
    check("no word after reset", words0, w);
    check("valid low after reset", b0.rx_valid, 0);

    for (int i = 0; i < 2000; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
